// File: rtl/graph_pkg.sv
// graph_pkg: shared event type and default sensor/graph geometry for the normaliser.
package graph_pkg;
   localparam int DEF_MAX_X_COORD  = 240;
   localparam int DEF_MAX_Y_COORD  = 180;
   localparam int DEF_GRAPH_SIZE_X = 128;
   localparam int DEF_GRAPH_SIZE_Y = 128;
   localparam int DEF_GRAPH_SIZE_T = 128;
   localparam int GX_BITS = $clog2(DEF_GRAPH_SIZE_X);
   localparam int GY_BITS = $clog2(DEF_GRAPH_SIZE_Y);
   localparam int GT_BITS = $clog2(DEF_GRAPH_SIZE_T);
   typedef struct packed {
      logic [GX_BITS-1:0] x;
      logic [GY_BITS-1:0] y;
      logic [GT_BITS-1:0] t;
      logic               p;
      logic               valid;
   } event_type;
endpackage

// File: rtl/norm_window_tracker.sv
// norm_window_tracker: stage-1 sliding time window state, window-relative delta and
// detection of window-opening and backwards-timestamp events.
module norm_window_tracker import graph_pkg::*; #(
   parameter int INPUT_BIT_TIME = 32,
   parameter int TIME_WINDOW    = 50000,
   parameter int CNT_BITS       = 16,
   parameter int DW             = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      accept,
   input  logic                      coord_ok,
   input  logic [INPUT_BIT_TIME-1:0] ts,
   output logic [DW-1:0]             delta,
   output logic                      new_win,
   output logic                      back,
   output logic                      ts_error,
   output logic [CNT_BITS-1:0]       window_count
);
   logic [INPUT_BIT_TIME-1:0] window_start;
   logic [INPUT_BIT_TIME-1:0] diff;
   logic                      window_open;

   // delta is only meaningful for kept, non-opening events, where it is < TIME_WINDOW
   always_comb begin
      diff    = ts - window_start;
      back    = coord_ok && window_open && ts < window_start;
      new_win = coord_ok && (!window_open || (!back && diff >= INPUT_BIT_TIME'(TIME_WINDOW)));
      delta   = new_win ? '0 : DW'(diff);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         window_start <= '0;
         window_open  <= 1'b0;
         ts_error     <= 1'b0;
         window_count <= '0;
      end else if (accept) begin
         if (new_win) begin
            window_start <= ts;
            window_open  <= 1'b1;
            if (window_count != '1) window_count <= window_count + CNT_BITS'(1);
         end
         if (back) ts_error <= 1'b1;
      end
   end
endmodule

// File: rtl/event_normalizer.sv
// event_normalizer: 3-stage classify/multiply/divide pipeline rescaling DVS events onto
// the graph grid, with window tracking, malformed-event dropping and counters.
module event_normalizer import graph_pkg::*; #(
   parameter int MAX_X_COORD    = DEF_MAX_X_COORD,
   parameter int MAX_Y_COORD    = DEF_MAX_Y_COORD,
   parameter int GRAPH_SIZE_X   = DEF_GRAPH_SIZE_X,
   parameter int GRAPH_SIZE_Y   = DEF_GRAPH_SIZE_Y,
   parameter int GRAPH_SIZE_T   = DEF_GRAPH_SIZE_T,
   parameter int INPUT_BIT_TIME = 32,
   parameter int INPUT_BIT_X    = 8,
   parameter int INPUT_BIT_Y    = 8,
   parameter int TIME_WINDOW    = 50000,
   parameter int CNT_BITS       = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [INPUT_BIT_TIME-1:0] in_timestamp,
   input  logic [INPUT_BIT_X-1:0]    in_x,
   input  logic [INPUT_BIT_Y-1:0]    in_y,
   input  logic                      in_polarity,
   input  logic                      in_valid,
   output logic                      in_ready,
   output event_type                 out_event,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      reset_context,
   output logic [CNT_BITS-1:0]       drop_count,
   output logic [CNT_BITS-1:0]       window_count,
   output logic                      ts_error
);
   localparam int DW  = $clog2(TIME_WINDOW + 1);
   localparam int PXW = $clog2(MAX_X_COORD * GRAPH_SIZE_X + 1);
   localparam int PYW = $clog2(MAX_Y_COORD * GRAPH_SIZE_Y + 1);
   localparam int PTW = $clog2(TIME_WINDOW * GRAPH_SIZE_T + 1);

   logic                   en, accept, coord_ok, new_win, back;
   logic [DW-1:0]          delta;
   logic                   s1_valid, s1_p, s1_new;
   logic [INPUT_BIT_X-1:0] s1_x;
   logic [INPUT_BIT_Y-1:0] s1_y;
   logic [DW-1:0]          s1_delta;
   logic                   s2_valid, s2_p, s2_new;
   logic [PXW-1:0]         s2_px;
   logic [PYW-1:0]         s2_py;
   logic [PTW-1:0]         s2_pt;
   logic [GX_BITS-1:0]     o_x;
   logic [GY_BITS-1:0]     o_y;
   logic [GT_BITS-1:0]     o_t;
   logic                   o_p;

   assign en        = !out_valid || out_ready;
   assign in_ready  = en;
   assign accept    = in_valid && en;
   assign coord_ok  = int'(in_x) < MAX_X_COORD && int'(in_y) < MAX_Y_COORD;
   assign out_event = '{x: o_x, y: o_y, t: o_t, p: o_p, valid: out_valid};

   norm_window_tracker #(
      .INPUT_BIT_TIME(INPUT_BIT_TIME),
      .TIME_WINDOW   (TIME_WINDOW),
      .CNT_BITS      (CNT_BITS),
      .DW            (DW)
   ) u_tracker (
      .clk         (clk),
      .reset       (reset),
      .accept      (accept),
      .coord_ok    (coord_ok),
      .ts          (in_timestamp),
      .delta       (delta),
      .new_win     (new_win),
      .back        (back),
      .ts_error    (ts_error),
      .window_count(window_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_count    <= '0;
         s1_valid      <= 1'b0;
         s1_p          <= 1'b0;
         s1_new        <= 1'b0;
         s1_x          <= '0;
         s1_y          <= '0;
         s1_delta      <= '0;
         s2_valid      <= 1'b0;
         s2_p          <= 1'b0;
         s2_new        <= 1'b0;
         s2_px         <= '0;
         s2_py         <= '0;
         s2_pt         <= '0;
         out_valid     <= 1'b0;
         reset_context <= 1'b0;
         o_x           <= '0;
         o_y           <= '0;
         o_t           <= '0;
         o_p           <= 1'b0;
      end else begin
         if (accept && (!coord_ok || back) && drop_count != '1)
            drop_count <= drop_count + CNT_BITS'(1);
         if (en) begin
            // dropped events still occupy the slot, just with valid cleared
            s1_valid      <= accept && coord_ok && !back;
            s1_p          <= in_polarity;
            s1_new        <= new_win;
            s1_x          <= in_x;
            s1_y          <= in_y;
            s1_delta      <= delta;
            s2_valid      <= s1_valid;
            s2_p          <= s1_p;
            s2_new        <= s1_new;
            s2_px         <= PXW'(s1_x) * PXW'(GRAPH_SIZE_X);
            s2_py         <= PYW'(s1_y) * PYW'(GRAPH_SIZE_Y);
            s2_pt         <= PTW'(s1_delta) * PTW'(GRAPH_SIZE_T);
            out_valid     <= s2_valid;
            reset_context <= s2_valid && s2_new;
            o_x           <= GX_BITS'(s2_px / PXW'(MAX_X_COORD));
            o_y           <= GY_BITS'(s2_py / PYW'(MAX_Y_COORD));
            o_t           <= GT_BITS'(s2_pt / PTW'(TIME_WINDOW));
            o_p           <= s2_p;
         end
      end
   end
endmodule

// File: tb/tb_event_normalizer.sv
// tb_event_normalizer: directed and randomized checks of event_normalizer against a
// queue-based reference model of the windowing and rescaling rules.
module tb_event_normalizer;
   import graph_pkg::*;
   localparam int TW = 50000;

   logic        clk = 0, reset = 0;
   logic [31:0] in_timestamp = '0;
   logic [7:0]  in_x = '0, in_y = '0;
   logic        in_polarity = 0, in_valid = 0, in_ready;
   event_type   out_event;
   logic        out_valid, out_ready = 1, reset_context, ts_error;
   logic [15:0] drop_count, window_count;

   always #5 clk = ~clk;

   event_normalizer dut (
      .clk          (clk),
      .reset        (reset),
      .in_timestamp (in_timestamp),
      .in_x         (in_x),
      .in_y         (in_y),
      .in_polarity  (in_polarity),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_event    (out_event),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .reset_context(reset_context),
      .drop_count   (drop_count),
      .window_count (window_count),
      .ts_error     (ts_error)
   );

   typedef struct {int x; int y; int t; bit p; bit rc;} exp_t;
   exp_t      q[$];
   int        tests = 0, fails = 0, recv = 0;
   longint    m_start;
   bit        m_open, m_err;
   int        m_drops, m_wins;
   int        last_x, last_y, last_t;
   bit        last_p, last_rc;
   bit        hold_v = 0, hold_rc, rand_done;
   event_type hold_e;

   function automatic void model_reset();
      q.delete();
      m_start = 0; m_open = 0; m_err = 0; m_drops = 0; m_wins = 0;
   endfunction

   function automatic void model_accept(input longint ts, input int x, input int y, input bit p);
      exp_t e;
      bit   nw;
      if (x >= 240 || y >= 180) begin
         if (m_drops < 65535) m_drops++;
         return;
      end
      if (m_open && ts < m_start) begin
         if (m_drops < 65535) m_drops++;
         m_err = 1;
         return;
      end
      nw = !m_open || (ts - m_start >= TW);
      if (nw) begin
         m_start = ts; m_open = 1;
         if (m_wins < 65535) m_wins++;
      end
      e.x = x * 128 / 240;
      e.y = y * 128 / 180;
      e.t = int'((ts - m_start) * 128 / TW);
      e.p = p;
      e.rc = nw;
      q.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         if (hold_v) begin
            tests++;
            if (out_event !== hold_e || out_valid !== 1'b1 || reset_context !== hold_rc) begin
               fails++;
               $display("FAIL stall_hold got ev=%h rc=%b expected ev=%h rc=%b", out_event, reset_context, hold_e, hold_rc);
            end
         end
         hold_v  = out_valid && !out_ready;
         hold_e  = out_event;
         hold_rc = reset_context;
         if (out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output got x=%0d y=%0d t=%0d expected no event", out_event.x, out_event.y, out_event.t);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (out_event.x !== GX_BITS'(e.x) || out_event.y !== GY_BITS'(e.y) || out_event.t !== GT_BITS'(e.t) ||
                   out_event.p !== e.p || reset_context !== e.rc || out_event.valid !== 1'b1) begin
                  fails++;
                  $display("FAIL out_event got x=%0d y=%0d t=%0d p=%b rc=%b v=%b expected x=%0d y=%0d t=%0d p=%b rc=%b v=1",
                           out_event.x, out_event.y, out_event.t, out_event.p, reset_context, out_event.valid,
                           e.x, e.y, e.t, e.p, e.rc);
               end
            end
            recv++;
            last_x = int'(out_event.x); last_y = int'(out_event.y); last_t = int'(out_event.t);
            last_p = out_event.p; last_rc = reset_context;
         end
      end else hold_v = 0;
   end

   task automatic send(input longint ts, input int x, input int y, input bit p);
      int n = 0;
      in_timestamp = ts[31:0]; in_x = x[7:0]; in_y = y[7:0]; in_polarity = p; in_valid = 1;
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout got in_ready=0 expected 1");
         in_valid = 0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 0;
      model_accept(ts, x, y, p);
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (q.size() != 0 || out_valid) begin
         fails++;
         $display("FAIL drain_timeout got pending=%0d expected 0", q.size());
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      model_reset();
      reset = 0;
      repeat (3) @(negedge clk);
      tests++;
      if (out_valid !== 0 || out_event !== '0 || reset_context !== 0) begin
         fails++; $display("FAIL reset_outputs got v=%b ev=%h rc=%b expected 0", out_valid, out_event, reset_context);
      end
      tests++;
      if (drop_count !== 0 || window_count !== 0 || ts_error !== 0) begin
         fails++; $display("FAIL reset_counters got d=%0d w=%0d e=%b expected 0", drop_count, window_count, ts_error);
      end
      reset = 1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      int n = 0, r0;
      out_ready = 1;
      send(1000, 120, 90, 1);
      while (!out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n != 2) begin fails++; $display("FAIL latency got %0d expected 2", n); end
      drain();
      tests++;
      if (last_x != 64 || last_y != 64 || last_t != 0 || last_p != 1 || last_rc != 1 || window_count !== 1) begin
         fails++; $display("FAIL first_event got x=%0d y=%0d t=%0d p=%b rc=%b w=%0d expected 64 64 0 1 1 1",
                           last_x, last_y, last_t, last_p, last_rc, window_count);
      end
      send(26000, 239, 179, 0);
      drain();
      tests++;
      if (last_x != 127 || last_y != 127 || last_t != 64 || last_rc != 0) begin
         fails++; $display("FAIL edge_coords got x=%0d y=%0d t=%0d rc=%b expected 127 127 64 0", last_x, last_y, last_t, last_rc);
      end
      send(51000, 10, 10, 1);
      drain();
      tests++;
      if (last_t != 0 || last_rc != 1 || window_count !== 2) begin
         fails++; $display("FAIL new_window got t=%0d rc=%b w=%0d expected 0 1 2", last_t, last_rc, window_count);
      end
      r0 = recv;
      send(50999, 10, 10, 1);
      drain();
      tests++;
      if (recv != r0 || ts_error !== 1 || drop_count !== 1) begin
         fails++; $display("FAIL backwards_ts got recv=%0d e=%b d=%0d expected %0d 1 1", recv, ts_error, drop_count, r0);
      end
   endtask

   task automatic test_coord_drop();
      int r0 = recv;
      send(120000, 240, 10, 0);
      send(121000, 5, 180, 1);
      drain();
      tests++;
      if (recv != r0 || drop_count !== 3 || window_count !== 2) begin
         fails++; $display("FAIL coord_drop got recv=%0d d=%0d w=%0d expected %0d 3 2", recv, drop_count, window_count, r0);
      end
      send(60000, 0, 0, 0);
      drain();
      tests++;
      if (last_t != 23 || last_rc != 0 || last_x != 0 || window_count !== 2) begin
         fails++; $display("FAIL after_drop got t=%0d rc=%b x=%0d w=%0d expected 23 0 0 2", last_t, last_rc, last_x, window_count);
      end
   endtask

   task automatic test_back_to_back();
      int r0 = recv;
      fork
         for (int i = 0; i < 10; i++) send(70000 + i * 100, i * 20, i * 15, i[0]);
         for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1 out_ready = !(c >= 4 && c <= 8);
            @(negedge clk);
            if (!out_ready && out_valid) begin
               tests++;
               if (in_ready !== 0) begin fails++; $display("FAIL stall_in_ready got %b expected 0", in_ready); end
            end
         end
      join
      out_ready = 1;
      drain();
      tests++;
      if (recv - r0 != 10) begin fails++; $display("FAIL b2b_count got %0d expected 10", recv - r0); end
   endtask

   task automatic test_random();
      longint cur = 200000;
      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               int x, y, r;
               r = $urandom_range(0, 99);
               cur += $urandom_range(0, 3000);
               if (r < 5) cur -= $urandom_range(1, 500);
               else if (r < 8) cur += 60000;
               x = $urandom_range(0, 239);
               y = $urandom_range(0, 179);
               r = $urandom_range(0, 19);
               if (r == 0) x = $urandom_range(240, 255);
               else if (r == 1) y = $urandom_range(180, 255);
               send(cur, x, y, 1'($urandom_range(0, 1)));
            end
            rand_done = 1;
         end
         while (!rand_done) begin
            @(posedge clk);
            #1 out_ready = $urandom_range(0, 3) != 0;
         end
      join
      out_ready = 1;
      drain();
      tests++;
      if (drop_count !== 16'(m_drops) || window_count !== 16'(m_wins) || ts_error !== m_err) begin
         fails++; $display("FAIL random_counters got d=%0d w=%0d e=%b expected %0d %0d %b",
                           drop_count, window_count, ts_error, m_drops, m_wins, m_err);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1;
      send(300000000, 1, 1, 0);
      send(300000010, 2, 2, 1);
      send(300000020, 3, 3, 0);
      #2 reset = 0;
      #1;
      tests++;
      if (out_valid !== 0 || reset_context !== 0 || window_count !== 0 || drop_count !== 0) begin
         fails++; $display("FAIL async_reset got v=%b rc=%b w=%0d d=%0d expected 0", out_valid, reset_context, window_count, drop_count);
      end
      model_reset();
      @(negedge clk);
      #2 reset = 1;
      @(negedge clk);
      send(5000, 60, 45, 1);
      drain();
      tests++;
      if (last_rc != 1 || window_count !== 1 || ts_error !== 0 || last_x != 32 || last_y != 32) begin
         fails++; $display("FAIL post_reset got rc=%b w=%0d e=%b x=%0d y=%0d expected 1 1 0 32 32",
                           last_rc, window_count, ts_error, last_x, last_y);
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_coord_drop();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
